// File: rtl/mem_ctrl_pkg.sv
// Shared state, opcode and control-bundle definitions for the memory-access sequencer.
package mem_ctrl_pkg;

   localparam int unsigned OP_W  = 5;
   localparam int unsigned ALU_W = 4;
   localparam int unsigned BUS_W = 5;

   typedef enum logic [3:0] {
      IDLE, T0, T1, T2, T3, T4, T5, T6, T7, ERR, DONE
   } state_t;

   typedef enum logic [1:0] {
      CLS_LD, CLS_LDI, CLS_ST, CLS_ILL
   } op_class_t;

   localparam logic [OP_W-1:0]  OP_LD   = 5'b00000;
   localparam logic [OP_W-1:0]  OP_LDI  = 5'b00001;
   localparam logic [OP_W-1:0]  OP_ST   = 5'b00010;

   localparam logic [ALU_W-1:0] ALU_ADD = 4'b0011;

   localparam logic [BUS_W-1:0] BUS_GPR = 5'b00000;
   localparam logic [BUS_W-1:0] BUS_ZLO = 5'b10011;
   localparam logic [BUS_W-1:0] BUS_PC  = 5'b10100;
   localparam logic [BUS_W-1:0] BUS_MDR = 5'b10101;

   // One field per datapath control port plus the handshake flags.
   typedef struct packed {
      logic             busy;
      logic             done;
      logic             illegal;
      logic             inc_pc;
      logic             e_pc;
      logic             e_ir;
      logic             e_y;
      logic             e_z;
      logic             e_mar;
      logic             e_mdr;
      logic             mdr_read;
      logic             ram_read;
      logic             ram_write;
      logic             gra;
      logic             grb;
      logic             e_rin;
      logic             e_rout;
      logic             ba_out;
      logic             imm_sel;
      logic [ALU_W-1:0] alu_op;
      logic [BUS_W-1:0] bus_sel;
   } ctrl_t;

   function automatic op_class_t classify(input logic [OP_W-1:0] opc);
      case (opc)
         OP_LD:   classify = CLS_LD;
         OP_LDI:  classify = CLS_LDI;
         OP_ST:   classify = CLS_ST;
         default: classify = CLS_ILL;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_decode.sv
// Moore output decode: maps a sequencer state to the datapath control bundle.
module mem_ctrl_decode
   import mem_ctrl_pkg::*;
(
   input  state_t    state,
   input  op_class_t op_class,
   input  logic      last_wait,
   output ctrl_t     ctrl
);

   always_comb begin
      ctrl      = '0;
      ctrl.busy = (state != IDLE);
      case (state)
         T0: begin
            ctrl.bus_sel = BUS_PC;
            ctrl.e_mar   = 1'b1;
            ctrl.inc_pc  = 1'b1;
            ctrl.e_z     = 1'b1;
         end
         T1: begin
            ctrl.bus_sel  = BUS_ZLO;
            ctrl.e_pc     = 1'b1;
            ctrl.ram_read = 1'b1;
            ctrl.mdr_read = last_wait;
            ctrl.e_mdr    = last_wait;
         end
         T2: begin
            ctrl.bus_sel = BUS_MDR;
            ctrl.e_ir    = 1'b1;
         end
         // BAout forces R0 to read as zero for the base register.
         T3: begin
            ctrl.bus_sel = BUS_GPR;
            ctrl.grb     = 1'b1;
            ctrl.e_rout  = 1'b1;
            ctrl.e_y     = 1'b1;
            ctrl.ba_out  = 1'b1;
         end
         T4: begin
            ctrl.imm_sel = 1'b1;
            ctrl.alu_op  = ALU_ADD;
            ctrl.e_z     = 1'b1;
         end
         T5: begin
            ctrl.bus_sel = BUS_ZLO;
            if (op_class == CLS_LDI) begin
               ctrl.gra   = 1'b1;
               ctrl.e_rin = 1'b1;
            end else begin
               ctrl.e_mar = 1'b1;
            end
         end
         T6: begin
            if (op_class == CLS_ST) begin
               ctrl.bus_sel = BUS_GPR;
               ctrl.gra     = 1'b1;
               ctrl.e_rout  = 1'b1;
               ctrl.e_mdr   = 1'b1;
            end else begin
               ctrl.ram_read = 1'b1;
               ctrl.mdr_read = last_wait;
               ctrl.e_mdr    = last_wait;
            end
         end
         T7: begin
            if (op_class == CLS_ST) begin
               ctrl.ram_write = 1'b1;
            end else begin
               ctrl.bus_sel = BUS_MDR;
               ctrl.gra     = 1'b1;
               ctrl.e_rin   = 1'b1;
            end
         end
         ERR:     ctrl.illegal = 1'b1;
         DONE:    ctrl.done    = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_ctrl_seq.sv
// Fetch/execute sequencer for ld, ldi and st; drives the datapath control ports.
module mem_ctrl_seq
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned RAM_LAT = 1,
   parameter int unsigned OPC_W   = 5
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [OPC_W-1:0] ir_opcode,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic             incPC,
   output logic             e_PC,
   output logic             e_IR,
   output logic             e_Y,
   output logic             e_Z,
   output logic             e_MAR,
   output logic             e_MDR,
   output logic             MDR_read,
   output logic             ram_read,
   output logic             ram_write,
   output logic             Gra,
   output logic             Grb,
   output logic             e_Rin,
   output logic             e_Rout,
   output logic             BAout,
   output logic             imm_sel,
   output logic [3:0]       ALU_op,
   output logic [4:0]       BusDataSelect
);

   localparam int unsigned      CNT_W    = $clog2(RAM_LAT) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RAM_LAT - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = '1;

   state_t           state_q, state_n;
   op_class_t        cls_q, cls_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             wait_over;
   logic             last_n;
   ctrl_t            ctrl_n, ctrl_q;

   assign wait_over = (cnt_q == LAST_CNT);

   // Opcode class is taken at the end of T3, when IR has settled.
   always_comb begin
      cls_n = cls_q;
      if (state_q == T3) cls_n = classify(OP_W'(ir_opcode));
   end

   // Next-state logic; start is only honoured from IDLE.
   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE: if (start) state_n = T0;
         T0:   state_n = T1;
         T1:   if (wait_over) state_n = T2;
         T2:   state_n = T3;
         T3:   state_n = (cls_n == CLS_ILL) ? ERR : T4;
         T4:   state_n = T5;
         T5:   state_n = (cls_q == CLS_LDI) ? DONE : T6;
         T6:   if (cls_q == CLS_ST || wait_over) state_n = T7;
         T7:   if (cls_q == CLS_LD || wait_over) state_n = DONE;
         ERR:  state_n = IDLE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Wait counter restarts on every state change and saturates.
   always_comb begin
      cnt_n = cnt_q;
      if (state_n != state_q)  cnt_n = '0;
      else if (cnt_q != MAX_CNT) cnt_n = cnt_q + CNT_W'(1);
      last_n = (cnt_n == LAST_CNT);
   end

   // Decode the upcoming state so the registered outputs line up with state_q.
   mem_ctrl_decode u_decode (
      .state     (state_n),
      .op_class  (cls_n),
      .last_wait (last_n),
      .ctrl      (ctrl_n)
   );

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= IDLE;
         cls_q   <= CLS_LD;
         cnt_q   <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_n;
         cls_q   <= cls_n;
         cnt_q   <= cnt_n;
         ctrl_q  <= ctrl_n;
      end
   end

   assign busy          = ctrl_q.busy;
   assign done          = ctrl_q.done;
   assign illegal       = ctrl_q.illegal;
   assign incPC         = ctrl_q.inc_pc;
   assign e_PC          = ctrl_q.e_pc;
   assign e_IR          = ctrl_q.e_ir;
   assign e_Y           = ctrl_q.e_y;
   assign e_Z           = ctrl_q.e_z;
   assign e_MAR         = ctrl_q.e_mar;
   assign e_MDR         = ctrl_q.e_mdr;
   assign MDR_read      = ctrl_q.mdr_read;
   assign ram_read      = ctrl_q.ram_read;
   assign ram_write     = ctrl_q.ram_write;
   assign Gra           = ctrl_q.gra;
   assign Grb           = ctrl_q.grb;
   assign e_Rin         = ctrl_q.e_rin;
   assign e_Rout        = ctrl_q.e_rout;
   assign BAout         = ctrl_q.ba_out;
   assign imm_sel       = ctrl_q.imm_sel;
   assign ALU_op        = ctrl_q.alu_op;
   assign BusDataSelect = ctrl_q.bus_sel;

endmodule

// File: tb/tb_mem_ctrl_seq.sv
// Directed bench: sequencer driving a small behavioural datapath, plus a RAM_LAT=3 instance.
module tb_mem_ctrl_seq;

   logic       clock = 1'b0;
   logic       clear, start, start3;
   logic [4:0] ir_opcode, ir3;

   logic incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read, ram_read, ram_write;
   logic Gra, Grb, e_Rin, e_Rout, BAout, imm_sel, busy, done, illegal;
   logic [3:0] ALU_op;
   logic [4:0] BusDataSelect;

   logic incPC_3, e_PC_3, e_IR_3, e_Y_3, e_Z_3, e_MAR_3, e_MDR_3, MDR_read_3, ram_read_3, ram_write_3;
   logic Gra_3, Grb_3, e_Rin_3, e_Rout_3, BAout_3, imm_sel_3, busy_3, done_3, illegal_3;
   logic [3:0] ALU_op_3;
   logic [4:0] BusDataSelect_3;

   logic [27:0] ctrl_vec, ctrl_vec3;
   assign ctrl_vec  = {incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, MDR_read, ram_read, ram_write,
                       Gra, Grb, e_Rin, e_Rout, BAout, imm_sel, busy, done, illegal, ALU_op, BusDataSelect};
   assign ctrl_vec3 = {incPC_3, e_PC_3, e_IR_3, e_Y_3, e_Z_3, e_MAR_3, e_MDR_3, MDR_read_3, ram_read_3,
                       ram_write_3, Gra_3, Grb_3, e_Rin_3, e_Rout_3, BAout_3, imm_sel_3, busy_3, done_3,
                       illegal_3, ALU_op_3, BusDataSelect_3};

   always #5 clock = ~clock;

   mem_ctrl_seq #(.RAM_LAT(1), .OPC_W(5)) u_dut (
      .clock(clock), .clear(clear), .start(start), .ir_opcode(ir_opcode),
      .busy(busy), .done(done), .illegal(illegal),
      .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_MAR(e_MAR),
      .e_MDR(e_MDR), .MDR_read(MDR_read), .ram_read(ram_read), .ram_write(ram_write),
      .Gra(Gra), .Grb(Grb), .e_Rin(e_Rin), .e_Rout(e_Rout), .BAout(BAout), .imm_sel(imm_sel),
      .ALU_op(ALU_op), .BusDataSelect(BusDataSelect)
   );

   mem_ctrl_seq #(.RAM_LAT(3), .OPC_W(5)) u_dut3 (
      .clock(clock), .clear(clear), .start(start3), .ir_opcode(ir3),
      .busy(busy_3), .done(done_3), .illegal(illegal_3),
      .incPC(incPC_3), .e_PC(e_PC_3), .e_IR(e_IR_3), .e_Y(e_Y_3), .e_Z(e_Z_3), .e_MAR(e_MAR_3),
      .e_MDR(e_MDR_3), .MDR_read(MDR_read_3), .ram_read(ram_read_3), .ram_write(ram_write_3),
      .Gra(Gra_3), .Grb(Grb_3), .e_Rin(e_Rin_3), .e_Rout(e_Rout_3), .BAout(BAout_3), .imm_sel(imm_sel_3),
      .ALU_op(ALU_op_3), .BusDataSelect(BusDataSelect_3)
   );

   // Behavioural datapath: register file, PC, IR, MAR, MDR, Y, Z and a 256-word RAM.
   logic [31:0] rf  [16]  = '{default: 32'h0};
   logic [31:0] ram [256] = '{default: 32'h0};
   logic [31:0] pc = '0, ir = '0, mdr = '0, y = '0, z = '0;
   logic [7:0]  mar = '0;
   logic [31:0] bus, c_sext;
   logic [3:0]  rsel;
   logic [1:0]  poke_kind = 2'd0;
   logic [7:0]  poke_addr = '0;
   logic [31:0] poke_val  = '0;

   assign ir_opcode = ir[31:27];

   always_comb begin
      c_sext = {{13{ir[18]}}, ir[18:0]};
      rsel   = Gra ? ir[26:23] : ir[22:19];
      case (BusDataSelect)
         5'b00000: bus = (BAout && rsel == 4'd0) ? 32'h0 : rf[rsel];
         5'b10011: bus = z;
         5'b10100: bus = pc;
         5'b10101: bus = mdr;
         default:  bus = 32'h0;
      endcase
   end

   always @(posedge clock) begin
      if (poke_kind == 2'd1) rf[poke_addr[3:0]] <= poke_val;
      else if (poke_kind == 2'd2) ram[poke_addr] <= poke_val;
      else begin
         if (e_MAR) mar <= bus[7:0];
         if (e_Z)   z   <= incPC ? bus + 32'd1 : ((ALU_op == 4'b0011) ? y + (imm_sel ? c_sext : bus) : z);
         if (e_Y)   y   <= bus;
         if (e_PC)  pc  <= bus;
         if (e_IR)  ir  <= bus;
         if (e_MDR) mdr <= MDR_read ? ram[mar] : bus;
         if (e_Rin) rf[rsel] <= bus;
         if (ram_write) ram[mar] <= mdr;
      end
   end

   // Event counters and the mutual-exclusion monitor.
   int done_cnt = 0, wr_cnt = 0, ill_cnt = 0, rin_cnt = 0, excl_viol = 0, rd3_cnt = 0, wr3_cnt = 0;
   logic [7:0] last_rd_mar = '0;
   always @(posedge clock) begin
      if (done)      done_cnt <= done_cnt + 1;
      if (ram_write) wr_cnt   <= wr_cnt + 1;
      if (illegal)   ill_cnt  <= ill_cnt + 1;
      if (e_Rin)     rin_cnt  <= rin_cnt + 1;
      if (ram_read)  last_rd_mar <= mar;
      if (ram_read_3)  rd3_cnt <= rd3_cnt + 1;
      if (ram_write_3) wr3_cnt <= wr3_cnt + 1;
      if ((ram_read && ram_write) || (e_Rin && e_Rout) ||
          (ram_read_3 && ram_write_3) || (e_Rin_3 && e_Rout_3))
         excl_viol <= excl_viol + 1;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [1:0] kind, input logic [7:0] addr, input logic [31:0] val);
      @(negedge clock);
      poke_kind = kind; poke_addr = addr; poke_val = val;
      @(negedge clock);
      poke_kind = 2'd0;
   endtask

   // Pulse start, count cycles to done/illegal, then settle one more cycle.
   task automatic run_instr(output int lat, output logic [27:0] first);
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      lat   = 1;
      first = ctrl_vec;
      while (!(done || illegal) && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      @(negedge clock);
   endtask

   initial begin
      int          lat;
      logic [27:0] first;
      logic [27:0] exp_t0;
      int          d0, w0, i0, r0;

      exp_t0 = {10'b1000110000, 6'b000000, 3'b100, 4'b0000, 5'b10100};
      clear = 1'b0; start = 1'b0; start3 = 1'b0; ir3 = 5'b00010;
      repeat (2) @(negedge clock);
      check("reset_outputs", 32'(ctrl_vec), 32'h0);
      check("reset_outputs_lat3", 32'(ctrl_vec3), 32'h0);

      poke(2'd2, 8'h00, 32'h09000078);
      poke(2'd2, 8'h01, 32'h03100063);
      poke(2'd2, 8'hDB, 32'hCAFE0001);
      poke(2'd2, 8'h02, 32'h1310001F);
      poke(2'd2, 8'h03, 32'h20000000);
      poke(2'd2, 8'h04, 32'h09800005);
      poke(2'd2, 8'h05, 32'h13100020);
      @(negedge clock); clear = 1'b1;
      @(negedge clock);

      // ldi R2, 0x78
      w0 = wr_cnt;
      run_instr(lat, first);
      check("ldi_t0_outputs", 32'(first), 32'(exp_t0));
      check("ldi_latency", 32'(lat), 32'd7);
      check("ldi_r2", rf[2], 32'h78);
      check("ldi_pc", pc, 32'd1);
      check("ldi_no_write", 32'(wr_cnt - w0), 32'd0);

      // ld R6, 0x63(R2)
      run_instr(lat, first);
      check("ld_latency", 32'(lat), 32'd9);
      check("ld_r6", rf[6], 32'hCAFE0001);
      check("ld_mar_t6", 32'(last_rd_mar), 32'hDB);
      check("ld_pc", pc, 32'd2);

      // st R6, 0x1F(R2)
      poke(2'd1, 8'd6, 32'h12345678);
      w0 = wr_cnt;
      run_instr(lat, first);
      check("st_latency", 32'(lat), 32'd9);
      check("st_ram97", ram[8'h97], 32'h12345678);
      check("st_one_write", 32'(wr_cnt - w0), 32'd1);
      check("st_r6_kept", rf[6], 32'h12345678);
      check("st_pc", pc, 32'd3);

      // illegal opcode 00100
      d0 = done_cnt; w0 = wr_cnt; i0 = ill_cnt; r0 = rin_cnt;
      run_instr(lat, first);
      check("ill_latency", 32'(lat), 32'd5);
      check("ill_pulse", 32'(ill_cnt - i0), 32'd1);
      check("ill_no_done", 32'(done_cnt - d0), 32'd0);
      check("ill_no_rin", 32'(rin_cnt - r0), 32'd0);
      check("ill_no_write", 32'(wr_cnt - w0), 32'd0);
      check("ill_idle", 32'(busy), 32'd0);

      // ldi R3, 5 with start re-pulsed mid-instruction and on the DONE cycle
      d0 = done_cnt;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         start = (i == 2) || done;
         @(negedge clock);
      end
      start = 1'b0;
      @(negedge clock);
      check("busy_one_done", 32'(done_cnt - d0), 32'd1);
      check("busy_idle_after", 32'(busy), 32'd0);
      check("busy_r3", rf[3], 32'd5);

      // st to 0x98, aborted by clear during T6
      w0 = wr_cnt;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      lat = 1;
      while (!(e_MDR && e_Rout) && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      check("abort_reach_t6", 32'(lat), 32'd7);
      #2 clear = 1'b0;
      #1 check("abort_async_outputs", 32'(ctrl_vec), 32'h0);
      repeat (4) @(negedge clock);
      check("abort_no_write", 32'(wr_cnt - w0), 32'd0);
      check("abort_ram98", ram[8'h98], 32'h0);
      clear = 1'b1;
      @(negedge clock);
      check("abort_idle_after", 32'(ctrl_vec), 32'h0);

      // RAM_LAT=3 instance running st
      d0 = rd3_cnt; w0 = wr3_cnt;
      @(negedge clock); start3 = 1'b1;
      @(negedge clock); start3 = 1'b0;
      lat = 1;
      while (!done_3 && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      @(negedge clock);
      check("lat3_latency", 32'(lat), 32'd13);
      check("lat3_read_cycles", 32'(rd3_cnt - d0), 32'd3);
      check("lat3_write_cycles", 32'(wr3_cnt - w0), 32'd3);
      check("lat3_idle_after", 32'(busy_3), 32'd0);

      check("strobe_exclusion", 32'(excl_viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
